ppu_frame_writer: RTL and testbench
===================================

PPU_FRAME_WRITER -- requirements
Module: ppu_frame_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of packed-byte write entries; power of two, 4 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port px_in, input, 2 bits: raw colour index from the PPU pixel FIFO.
REQ-005 SHALL have port px_valid, input, 1 bit: px_in is valid this cycle.
REQ-006 SHALL have port line_start, input, 1 bit: one-cycle pulse at DRAW entry of each scanline.
REQ-007 SHALL have port frame_start, input, 1 bit: one-cycle pulse at LY=0 SCAN entry.
REQ-008 SHALL have port bgp, input, 8 bits: BGP palette register (FF47).
REQ-009 SHALL have port fb_wr, output, 1 bit: frame-buffer write request.
REQ-010 SHALL have port fb_addr, output, 13 bits: frame-buffer byte address.
REQ-011 SHALL have port fb_data, output, 8 bits: four packed 2-bit shades.
REQ-012 SHALL have port fb_ready, input, 1 bit: frame buffer accepts the write this cycle.
REQ-013 SHALL have port line_done, output, 1 bit: one-cycle pulse after the 160th pixel of a line.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last pixel of line 143.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set when a packed byte was dropped.

Function
REQ-016 SHALL keep counters x (0..159) and y (0..143); each accepted pixel SHALL increment x.
REQ-017 SHALL ignore px_valid while x=160 (line saturated) until the next line_start.
REQ-018 SHALL pack shades MSB-first: the pixel at x%4=0 goes to bits [7:6] and the pixel at x%4=3 goes to bits [1:0].
REQ-019 SHALL push {addr = y*40 + x/4, data} into the FIFO in the cycle after the pixel with x%4=3 is accepted.
REQ-020 SHALL, with the FIFO empty, assert fb_wr in the cycle after the push, giving 2-cycle latency from the 4th pixel to fb_wr.
REQ-021 SHALL hold fb_wr, fb_addr and fb_data stable until fb_ready=1; a transfer occurs on fb_wr && fb_ready.
REQ-022 SHALL implement the write port as FSM IDLE -> WRITE when the FIFO is non-empty, WRITE -> WRITE on transfer with the FIFO still non-empty, and WRITE -> IDLE on transfer with the FIFO empty.
REQ-023 SHALL accept a push and a pop in the same cycle when the FIFO is full.
REQ-024 SHALL, when a push finds the FIFO full with no pop, drop the byte and set overflow, which holds until reset.
REQ-025 SHALL, on the 160th pixel, pulse line_done, increment y, and hold x at 160.
REQ-026 SHALL, when y=143 completes, pulse frame_done in the same cycle as line_done and wrap y to 0.
REQ-027 SHALL, on line_start, set x=0 and discard any partial byte; y SHALL be unchanged.
REQ-028 SHALL, on frame_start, set x=0 and y=0 and discard any partial byte; queued FIFO entries SHALL still drain.
REQ-029 SHALL, when line_start or frame_start coincides with px_valid, apply the start first and accept the pixel as x=0.
REQ-030 SHALL give frame_start priority over line_start when both are asserted together.

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge, clear x, y, the partial byte, the FIFO pointers and overflow, and set the FSM to IDLE.
REQ-032 SHALL hold the reset values fb_wr=0, fb_addr=0, fb_data=0, line_done=0, frame_done=0 and overflow=0.
REQ-033 SHALL, on reset during WRITE, deassert fb_wr in the next cycle; the pending write is abandoned.

Configuration
REQ-034 SHALL, with FWR_PALETTE_EN defined, write shade = bgp[2*px_in+1 : 2*px_in], sampling bgp in the pixel's accept cycle.
REQ-035 SHALL, without FWR_PALETTE_EN, write px_in unchanged and leave bgp unused.

Structure
REQ-036 SHALL place LINE_PX=160, LINES=144, BYTES_PER_LINE=40, FB_ADDR_W=13 and the write-FSM enum typedef in package ppu_fb_pkg.
REQ-037 SHALL implement the FIFO as sub-module ppu_fb_fifo: synchronous, FIFO_DEPTH entries of 21 bits, with full/empty flags.

Verification
REQ-038 SHALL test palette mapping: FWR_PALETTE_EN, bgp=8'hE4, line_start, px_in 0,1,2,3 with fb_ready=1 -> fb_wr at addr 0 with data 8'h1B, 2 cycles after the 4th pixel.
REQ-039 SHALL test packing: bgp=8'h1B, pixels 3,3,0,0 at y=2, x=4..7 -> addr 81, data 8'h0F.
REQ-040 SHALL test backpressure: fb_ready=0 while 9 bytes are produced (FIFO_DEPTH=8) -> overflow=1, 8 entries drain in order once fb_ready=1, and addr/data stay stable while stalled.
REQ-041 SHALL test line end: 170 valid pixels after line_start -> 40 writes, one line_done, y+1, and pixels 161-170 ignored.
REQ-042 SHALL test mid-line restart: line_start after 6 pixels -> only the byte for x0-3 is written, and the next pixel lands in the x=0 slot.
REQ-043 SHALL test frame wrap: 144 full lines -> frame_done coincident with the final line_done, y=0, and the last write at addr 5759.

Source files
------------

// File: rtl/ppu_fb_pkg.sv
// Shared constants, write-port FSM states and FIFO entry layout for the PPU frame writer.
package ppu_fb_pkg;

   localparam int unsigned LINE_PX        = 160;
   localparam int unsigned LINES          = 144;
   localparam int unsigned BYTES_PER_LINE = 40;
   localparam int unsigned FB_ADDR_W      = 13;
   localparam int unsigned FB_ENTRY_W     = FB_ADDR_W + 8;

   typedef enum logic {
      WR_IDLE,
      WR_WRITE
   } wr_state_t;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [7:0]           data;
   } fb_entry_t;

   // Byte address of the 4-pixel group xq (= x/4) on line y.
   function automatic logic [FB_ADDR_W-1:0] fb_byte_addr(input logic [7:0] y, input logic [5:0] xq);
      return FB_ADDR_W'(y) * FB_ADDR_W'(BYTES_PER_LINE) + FB_ADDR_W'(xq);
   endfunction

endpackage

// File: rtl/ppu_frame_writer_if.sv
// Frame-buffer write bus: the writer is master, the frame buffer is slave.
interface ppu_frame_writer_if;
   import ppu_fb_pkg::*;

   logic                 fb_wr;
   logic [FB_ADDR_W-1:0] fb_addr;
   logic [7:0]           fb_data;
   logic                 fb_ready;

   modport master (
      output fb_wr,
      output fb_addr,
      output fb_data,
      input  fb_ready
   );

   modport slave (
      input  fb_wr,
      input  fb_addr,
      input  fb_data,
      output fb_ready
   );

endinterface

// File: rtl/ppu_fb_fifo.sv
// Synchronous FIFO of packed frame-buffer writes; exposes head and the entry behind it.
module ppu_fb_fifo
   import ppu_fb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  fb_entry_t push_data,
   input  logic      pop,
   output fb_entry_t head,
   output fb_entry_t head_next,
   output logic      empty,
   output logic      full,
   output logic      several
);

   fb_entry_t   mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] count;
   logic        do_push;
   logic        do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = count[AW];
   assign several = (count > (AW + 1)'(1));

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head      = mem[rd_ptr[AW-1:0]];
   assign head_next = mem[AW'(rd_ptr[AW-1:0] + 1'b1)];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ppu_frame_writer.sv
// Packs 2-bit PPU shades into frame-buffer bytes and streams them out through a FIFO.
// Optional BGP palette mapping is enabled with the FWR_PALETTE_EN macro.
module ppu_frame_writer
   import ppu_fb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] px_in,
   input  logic       px_valid,
   input  logic       line_start,
   input  logic       frame_start,
   input  logic [7:0] bgp,
   ppu_frame_writer_if.master fb,
   output logic       line_done,
   output logic       frame_done,
   output logic       overflow
);

   localparam logic [7:0] X_LAST = 8'(LINE_PX - 1);
   localparam logic [7:0] X_SAT  = 8'(LINE_PX);
   localparam logic [7:0] Y_LAST = 8'(LINES - 1);

   logic [7:0] x;
   logic [7:0] y;
   logic [7:0] pb;
   logic       push;
   fb_entry_t  push_entry;

   logic       start;
   logic [7:0] x_eff;
   logic [7:0] y_eff;
   logic [7:0] pb_new;
   logic       accept;
   logic [1:0] shade;

   wr_state_t  state;
   logic       xfer;
   fb_entry_t  fifo_head;
   fb_entry_t  fifo_head_next;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_several;

   // A start pulse takes effect before a coincident pixel, which lands at x=0.
   assign start  = frame_start || line_start;
   assign x_eff  = start ? '0 : x;
   assign y_eff  = frame_start ? '0 : y;
   assign accept = px_valid && (start || (x != X_SAT));

`ifdef FWR_PALETTE_EN
   always_comb begin
      shade = '0;
      case (px_in)
         2'd0: shade = bgp[1:0];
         2'd1: shade = bgp[3:2];
         2'd2: shade = bgp[5:4];
         2'd3: shade = bgp[7:6];
         default: shade = '0;
      endcase
   end
`else
   logic unused_bgp;
   assign unused_bgp = ^bgp;
   assign shade      = px_in;
`endif

   always_comb begin
      pb_new = start ? '0 : pb;
      case (x_eff[1:0])
         2'd0: pb_new[7:6] = shade;
         2'd1: pb_new[5:4] = shade;
         2'd2: pb_new[3:2] = shade;
         2'd3: pb_new[1:0] = shade;
         default: pb_new = pb;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x          <= '0;
         y          <= '0;
         pb         <= '0;
         push       <= 1'b0;
         push_entry <= '0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         push       <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         if (start) begin
            x  <= '0;
            pb <= '0;
         end
         if (frame_start) begin
            y <= '0;
         end
         if (accept) begin
            pb <= pb_new;
            if (x_eff[1:0] == 2'd3) begin
               push            <= 1'b1;
               push_entry.addr <= fb_byte_addr(y_eff, x_eff[7:2]);
               push_entry.data <= pb_new;
            end
            if (x_eff == X_LAST) begin
               x         <= X_SAT;
               line_done <= 1'b1;
               if (y_eff == Y_LAST) begin
                  y          <= '0;
                  frame_done <= 1'b1;
               end else begin
                  y <= y_eff + 8'd1;
               end
            end else begin
               x <= x_eff + 8'd1;
            end
         end
      end
   end

   assign xfer = fb.fb_wr && fb.fb_ready;

   ppu_fb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (xfer),
      .head      (fifo_head),
      .head_next (fifo_head_next),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .several   (fifo_several)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (push && fifo_full && !xfer) begin
         overflow <= 1'b1;
      end
   end

   // The output register shadows the FIFO head; an entry in flight still occupies
   // its FIFO slot until transferred. The push path is bypassed in so an empty
   // FIFO reaches fb_wr one cycle after the push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= WR_IDLE;
         fb.fb_wr   <= 1'b0;
         fb.fb_addr <= '0;
         fb.fb_data <= '0;
      end else begin
         case (state)
            WR_IDLE: begin
               if (!fifo_empty || push) begin
                  fb.fb_wr                 <= 1'b1;
                  state                    <= WR_WRITE;
                  {fb.fb_addr, fb.fb_data} <= fifo_empty ? push_entry : fifo_head;
               end
            end
            WR_WRITE: begin
               if (fb.fb_ready) begin
                  if (fifo_several) begin
                     {fb.fb_addr, fb.fb_data} <= fifo_head_next;
                  end else if (push) begin
                     {fb.fb_addr, fb.fb_data} <= push_entry;
                  end else begin
                     fb.fb_wr <= 1'b0;
                     state    <= WR_IDLE;
                  end
               end
            end
            default: begin
               fb.fb_wr <= 1'b0;
               state    <= WR_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Scoreboard bench for ppu_frame_writer: stimulus queues expected writes, a monitor checks them.
module tb_ppu_frame_writer;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] px_in = '0;
   logic       px_valid = 1'b0;
   logic       line_start = 1'b0;
   logic       frame_start = 1'b0;
   logic [7:0] bgp = 8'hE4;
   logic       line_done;
   logic       frame_done;
   logic       overflow;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ld_cnt = 0;
   int   fd_cnt = 0;
   int   wr_cnt = 0;
   int   last_addr = -1;
   int   last_data = -1;
   exp_t exp_q[$];

   int   bx = 0;
   int   by = 0;
   int   bpb = 0;
   bit   auto_exp = 1'b1;

   bit         stalled = 1'b0;
   logic [12:0] st_addr;
   logic [7:0]  st_data;

   ppu_frame_writer_if fb();

   ppu_frame_writer #(.FIFO_DEPTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .px_in       (px_in),
      .px_valid    (px_valid),
      .line_start  (line_start),
      .frame_start (frame_start),
      .bgp         (bgp),
      .fb          (fb),
      .line_done   (line_done),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (line_done) ld_cnt++;
         if (frame_done) begin
            fd_cnt++;
            checks++;
            if (line_done !== 1'b1) begin
               errors++;
               $display("FAIL frame_done_with_line_done got line_done=%b want 1", line_done);
            end
         end
         if (fb.fb_wr === 1'b1) begin
            if (stalled) begin
               checks++;
               if (fb.fb_addr !== st_addr || fb.fb_data !== st_data) begin
                  errors++;
                  $display("FAIL stall_stable got %0d/%h want %0d/%h", fb.fb_addr, fb.fb_data, st_addr, st_data);
               end
            end
            if (fb.fb_ready) begin
               stalled = 1'b0;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write got addr %0d data %h want none", fb.fb_addr, fb.fb_data);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (fb.fb_addr !== 13'(e.addr) || fb.fb_data !== 8'(e.data)) begin
                     errors++;
                     $display("FAIL write got addr %0d data %h want addr %0d data %h", fb.fb_addr, fb.fb_data, e.addr, e.data);
                  end
                  if (e.cyc >= 0) begin
                     checks++;
                     if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write_latency got cycle %0d want %0d", cyc, e.cyc);
                     end
                  end
               end
               last_addr = int'(fb.fb_addr);
               last_data = int'(fb.fb_data);
               wr_cnt++;
            end else begin
               stalled = 1'b1;
               st_addr = fb.fb_addr;
               st_data = fb.fb_data;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int map_shade(input int p);
`ifdef FWR_PALETTE_EN
      return (int'(bgp) >> (2 * p)) & 3;
`else
      return p;
`endif
   endfunction

   task automatic m_start(input bit frame);
      bx  = 0;
      bpb = 0;
      if (frame) by = 0;
   endtask

   task automatic m_px(input int p);
      if (bx == 160) return;
      if (bx % 4 == 0) bpb = 0;
      bpb = bpb | (map_shade(p) << (6 - 2 * (bx % 4)));
      if (bx % 4 == 3 && auto_exp) exp_q.push_back('{by * 40 + bx / 4, bpb, -1});
      bx++;
      if (bx == 160) by = (by == 143) ? 0 : by + 1;
   endtask

   task automatic drive(input int p, input bit ls, input bit fs, input bit v);
      px_in       = 2'(p);
      px_valid    = v;
      line_start  = ls;
      frame_start = fs;
      if (ls || fs) m_start(fs);
      if (v) m_px(p);
      step();
      px_valid    = 1'b0;
      line_start  = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic pix(input int p);
      drive(p, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic ls_pulse();
      drive(0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic pixels(input int n, input int seed);
      for (int i = 0; i < n; i++) pix((i * 5 + seed + (i >> 2)) % 4);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      step();
      step();
      chk({nm, "_drain_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int ld0, fd0, w0, n;

      fb.fb_ready = 1'b1;
      repeat (3) step();
      chk("rst_fb_wr", fb.fb_wr, 0);
      chk("rst_fb_addr", fb.fb_addr, 0);
      chk("rst_fb_data", fb.fb_data, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      step();

      // Palette/identity mapping and 2-cycle latency
      bgp = 8'hE4;
      ls_pulse();
      auto_exp = 1'b0;
      pix(0); pix(1); pix(2);
      exp_q.push_back('{0, 8'h1B, cyc + 2});
      pix(3);
      auto_exp = 1'b1;
      drain("latency");

      // Packing at y=2, x=4..7
      bgp = 8'h1B;
      drive(0, 1'b0, 1'b1, 1'b0);
      pixels(160, 1);
      ls_pulse();
      pixels(160, 2);
      ls_pulse();
      pixels(4, 3);
      auto_exp = 1'b0;
`ifdef FWR_PALETTE_EN
      exp_q.push_back('{81, 8'h0F, -1});
`else
      exp_q.push_back('{81, 8'hF0, -1});
`endif
      pix(3); pix(3); pix(0); pix(0);
      auto_exp = 1'b1;
      drain("packing");
      chk("packing_addr", last_addr, 81);

      // Line end: 170 pixels, last 10 ignored
      ld0 = ld_cnt;
      w0  = wr_cnt;
      ls_pulse();
      pixels(170, 0);
      drain("line_end");
      chk("line_end_line_done", ld_cnt - ld0, 1);
      chk("line_end_writes", wr_cnt - w0, 40);
      ls_pulse();
      pixels(4, 2);
      drain("line_next");
      chk("line_next_addr_y3", last_addr, 120);

      // Mid-line restart
      bgp = 8'hE4;
      w0  = wr_cnt;
      ls_pulse();
      pixels(6, 1);
      ls_pulse();
      pix(3); pix(0); pix(0); pix(0);
      drain("restart");
      chk("restart_writes", wr_cnt - w0, 2);
      chk("restart_addr", last_addr, 120);
      chk("restart_data", last_data, 8'hC0);
      chk("no_overflow_yet", overflow, 0);

      // Backpressure: 9 bytes into an 8-deep FIFO
      fb.fb_ready = 1'b0;
      w0 = wr_cnt;
      ls_pulse();
      pixels(36, 3);
      repeat (4) step();
      chk("bp_overflow", overflow, 1);
      chk("bp_fb_wr_held", fb.fb_wr, 1);
      chk("bp_head_addr", fb.fb_addr, 120);
      void'(exp_q.pop_back());
      fb.fb_ready = 1'b1;
      drain("backpressure");
      chk("bp_writes", wr_cnt - w0, 8);
      chk("bp_last_addr", last_addr, 127);
      chk("bp_overflow_sticky", overflow, 1);

      // Frame wrap; first pixel arrives with both start pulses
      ld0 = ld_cnt;
      fd0 = fd_cnt;
      drive(2, 1'b1, 1'b1, 1'b1);
      pixels(159, 0);
      for (int l = 1; l < 144; l++) begin
         ls_pulse();
         pixels(160, l);
      end
      drain("frame");
      chk("frame_done_count", fd_cnt - fd0, 1);
      chk("frame_line_done_count", ld_cnt - ld0, 144);
      chk("frame_last_addr", last_addr, 5759);
      ls_pulse();
      pixels(4, 1);
      drain("frame_wrap");
      chk("frame_wrap_addr", last_addr, 0);

      // Reset while a write is pending
      fb.fb_ready = 1'b0;
      ls_pulse();
      pixels(4, 0);
      n = 0;
      while (fb.fb_wr !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      chk("pre_reset_fb_wr", fb.fb_wr, 1);
      rst_n = 1'b0;
      step();
      chk("reset_write_fb_wr", fb.fb_wr, 0);
      chk("reset_write_overflow", overflow, 0);
      exp_q.delete();
      m_start(1'b1);
      rst_n = 1'b1;
      fb.fb_ready = 1'b1;
      repeat (4) step();
      chk("reset_write_abandoned", fb.fb_wr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
